// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register. The ready and valid outputs are decoded
// from registered state only, which breaks the ready path between neighbouring stages.
module pipe_skid_reg #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    output logic             up_ready_o,
    output logic             dn_valid_o,
    output logic [WIDTH-1:0] dn_data_o,
    input  logic             dn_ready_i,
    output logic [1:0]       occ_o,
    output logic [15:0]      stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             up_fire;
    logic             dn_fire;
    logic             stalled;

    assign up_ready_o = (state != FULL);
    assign dn_valid_o = (state != EMPTY);
    assign dn_data_o  = main_q;

    assign up_fire = up_valid_i & up_ready_o;
    assign dn_fire = dn_valid_o & dn_ready_i;
    assign stalled = dn_valid_o & ~dn_ready_i;

    always_comb begin
        occ_o = 2'd0;
        case (state)
            ONE:     occ_o = 2'd1;
            FULL:    occ_o = 2'd2;
            default: occ_o = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            main_q      <= RST_DATA;
            skid_q      <= RST_DATA;
            stall_cnt_o <= 16'd0;
        end else begin
            // Stall count survives flushes; only reset clears it.
            if (stalled && stall_cnt_o != 16'hFFFF)
                stall_cnt_o <= stall_cnt_o + 16'd1;

            // Flush drops all entries but leaves the data registers untouched.
            if (flush_i) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (up_fire) begin
                            main_q <= up_data_i;
                            state  <= ONE;
                        end
                    end
                    ONE: begin
                        if (up_fire && dn_fire) begin
                            main_q <= up_data_i;
                        end else if (up_fire) begin
                            skid_q <= up_data_i;
                            state  <= FULL;
                        end else if (dn_fire) begin
                            state <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (dn_fire) begin
                            main_q <= skid_q;
                            state  <= ONE;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: WIDTH=8 and WIDTH=64 instances run in lockstep against a
// queue-based reference model, with directed scenarios followed by random traffic.
module tb_pipe_skid_reg;

    localparam logic [7:0]  RST8  = 8'h5A;
    localparam logic [63:0] RST64 = 64'hDEAD_BEEF_0123_4567;

    logic        clk = 1'b0;
    logic        rst, flush, up_valid, dn_ready;
    logic [63:0] up_data;

    logic        up_ready8, dn_valid8, up_ready64, dn_valid64;
    logic [7:0]  dn_data8;
    logic [63:0] dn_data64;
    logic [1:0]  occ8, occ64;
    logic [15:0] stall8, stall64;

    int checks = 0;
    int errors = 0;

    // Reference model: list of held payloads (oldest first) and the stall count.
    logic [63:0] mq[$];
    int          m_stall;
    bit          m_valid = 1'b0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(8), .RST_DATA(RST8)) u8 (
        .clk(clk), .rst(rst), .flush_i(flush),
        .up_valid_i(up_valid), .up_data_i(up_data[7:0]), .up_ready_o(up_ready8),
        .dn_valid_o(dn_valid8), .dn_data_o(dn_data8), .dn_ready_i(dn_ready),
        .occ_o(occ8), .stall_cnt_o(stall8)
    );

    pipe_skid_reg #(.WIDTH(64), .RST_DATA(RST64)) u64 (
        .clk(clk), .rst(rst), .flush_i(flush),
        .up_valid_i(up_valid), .up_data_i(up_data), .up_ready_o(up_ready64),
        .dn_valid_o(dn_valid64), .dn_data_o(dn_data64), .dn_ready_i(dn_ready),
        .occ_o(occ64), .stall_cnt_o(stall64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance both.
    task automatic cyc(input logic uv, input logic [63:0] d, input logic dr,
                       input logic fl = 1'b0, input logic rs = 1'b0);
        bit m_up_fire, m_dn_fire;
        int n;
        rst = rs; flush = fl; up_data = d;
        // Opposite handshake inputs first: ready/valid outputs must not follow them.
        up_valid = ~uv; dn_ready = ~dr;
        #1;
        if (m_valid) begin
            chk("rdy8_nocomb",  {63'd0, up_ready8},  {63'd0, mq.size() < 2});
            chk("vld64_nocomb", {63'd0, dn_valid64}, {63'd0, mq.size() > 0});
        end
        up_valid = uv; dn_ready = dr;
        #1;
        if (m_valid) begin
            n = mq.size();
            chk("up_ready8",  {63'd0, up_ready8},  {63'd0, n < 2});
            chk("up_ready64", {63'd0, up_ready64}, {63'd0, n < 2});
            chk("dn_valid8",  {63'd0, dn_valid8},  {63'd0, n > 0});
            chk("dn_valid64", {63'd0, dn_valid64}, {63'd0, n > 0});
            chk("occ8",   {62'd0, occ8},  64'(n));
            chk("occ64",  {62'd0, occ64}, 64'(n));
            chk("stall8",  {48'd0, stall8},  64'(m_stall));
            chk("stall64", {48'd0, stall64}, 64'(m_stall));
            if (n > 0) begin
                chk("dn_data8",  {56'd0, dn_data8}, {56'd0, mq[0][7:0]});
                chk("dn_data64", dn_data64, mq[0]);
            end
        end
        n = mq.size();
        m_up_fire = uv && (n < 2);
        m_dn_fire = (n > 0) && dr;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_stall = 0;
            m_valid = 1'b1;
        end else begin
            if (n > 0 && !dr && m_stall < 16'hFFFF) m_stall++;
            if (fl) mq.delete();
            else begin
                if (m_dn_fire) void'(mq.pop_front());
                if (m_up_fire) mq.push_back(d);
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0; up_data = '0;
        m_stall = 0;

        // Reset state
        cyc(0, 0, 0, 0, 1);
        cyc(1, 64'h77, 1, 1, 1);
        chk("rst_up_ready", {63'd0, up_ready8}, 64'd1);
        chk("rst_dn_valid", {63'd0, dn_valid64}, 64'd0);
        chk("rst_occ", {62'd0, occ64}, 64'd0);
        chk("rst_data8", {56'd0, dn_data8}, {56'd0, RST8});
        chk("rst_data64", dn_data64, RST64);
        chk("rst_stall", {48'd0, stall8}, 64'd0);

        // Streaming at full rate
        cyc(1, 64'h11, 1);
        chk("stream_11", {56'd0, dn_data8}, 64'h11);
        cyc(1, 64'h22, 1);
        chk("stream_22", {56'd0, dn_data8}, 64'h22);
        chk("stream_occ", {62'd0, occ8}, 64'd1);
        cyc(1, 64'h33, 1);
        chk("stream_33", dn_data64, 64'h33);
        chk("stream_occ2", {62'd0, occ64}, 64'd1);
        cyc(0, 0, 1);
        chk("stream_stall", {48'd0, stall64}, 64'd0);
        chk("stream_drain", {63'd0, dn_valid8}, 64'd0);

        // Skid fill then drain in order
        cyc(1, 64'hA1, 0);
        chk("skid_occ1", {62'd0, occ8}, 64'd1);
        cyc(1, 64'hA2, 0);
        chk("skid_occ2", {62'd0, occ8}, 64'd2);
        chk("skid_not_ready", {63'd0, up_ready8}, 64'd0);
        cyc(1, 64'hA3, 0);
        chk("skid_held", {62'd0, occ64}, 64'd2);
        chk("skid_head", dn_data64, 64'hA1);
        cyc(1, 64'hA3, 1);
        chk("skid_out_a2", dn_data64, 64'hA2);
        cyc(1, 64'hA3, 1);
        chk("skid_out_a3", dn_data64, 64'hA3);
        cyc(0, 0, 1);
        chk("skid_stall", {48'd0, stall8}, 64'd2);

        // Flush from FULL with an upstream offer in the same cycle
        cyc(1, 64'hB1, 0);
        cyc(1, 64'hB2, 0);
        cyc(1, 64'hB3, 0, 1);
        chk("flush_occ", {62'd0, occ8}, 64'd0);
        chk("flush_valid", {63'd0, dn_valid64}, 64'd0);
        cyc(0, 0, 1);
        chk("flush_no_b3", {63'd0, dn_valid8}, 64'd0);

        // Reset mid-operation with flush also asserted
        cyc(1, 64'hD1, 0);
        cyc(1, 64'hD2, 0);
        cyc(0, 0, 0, 1, 1);
        chk("midrst_occ", {62'd0, occ64}, 64'd0);
        chk("midrst_data", dn_data64, RST64);
        chk("midrst_data8", {56'd0, dn_data8}, {56'd0, RST8});
        cyc(1, 64'hC1, 0);
        chk("midrst_c1", {56'd0, dn_data8}, 64'hC1);
        chk("midrst_c1_vld", {63'd0, dn_valid8}, 64'd1);

        // Stall counter saturation, survives flush, cleared by reset
        for (int i = 0; i < 65540 && errors < 20; i++) cyc(0, 0, 0);
        chk("sat_ffff", {48'd0, stall8}, 64'hFFFF);
        cyc(0, 0, 0);
        chk("sat_nowrap", {48'd0, stall64}, 64'hFFFF);
        cyc(0, 0, 0, 1);
        chk("sat_flush", {48'd0, stall64}, 64'hFFFF);
        cyc(0, 0, 0, 0, 1);
        chk("sat_rst", {48'd0, stall8}, 64'd0);

        // Random traffic with drifting back-pressure bias
        for (int i = 0; i < 12000 && errors < 20; i++) begin
            int bias;
            logic uv, dr, fl, rs;
            bias = (i / 1000) % 4;
            uv = ($urandom_range(3) != 0);
            dr = ($urandom_range(3) < bias + 1);
            fl = ($urandom_range(63) == 0);
            rs = ($urandom_range(511) == 0);
            cyc(uv, {$urandom, $urandom}, dr, fl, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
